// File: rtl/pci_arb_pkg.sv
// rtl/pci_arb_pkg.sv - shared types, defaults and helpers for the N-master PCI arbiter
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    GAP
  } arb_state_e;

  localparam int DEF_GNT_TIMEOUT = 16;
  localparam int DEF_AGE_W       = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pci_arb_pick.sv
// rtl/pci_arb_pick.sv - combinational winner selector: fixed priority or oldest-age-first
module pci_arb_pick
  import pci_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int AGE_W = DEF_AGE_W,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]       req_i,
  input  logic [N*AGE_W-1:0] age_i,
  input  logic               mode_i,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               win_vld_o
);

  logic [AGE_W-1:0] best_age;

  // Scanning upward with a strict compare keeps ties on the lowest index.
  always_comb begin
    win_idx_o = '0;
    win_vld_o = 1'b0;
    best_age  = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        if (!win_vld_o || (mode_i && (age_i[i*AGE_W +: AGE_W] > best_age))) begin
          win_vld_o = 1'b1;
          win_idx_o = IDX_W'(i);
          best_age  = age_i[i*AGE_W +: AGE_W];
        end
      end
    end
  end

endmodule

// File: rtl/pci_arbiter_n.sv
// rtl/pci_arbiter_n.sv - central PCI arbiter for N masters with hidden arbitration,
// grant gap, idle-grant timeout, optional parking and owner reporting
module pci_arbiter_n
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS   = 4,
  parameter int AGE_W       = DEF_AGE_W,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter bit PARK_EN     = 1'b1,
  parameter int PARK_IDX    = 0,
  localparam int OW         = clog2(N_MASTERS)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [N_MASTERS-1:0] REQ_n,
  input  logic                 FRAME_n,
  input  logic                 IRDY_n,
  input  logic                 Mode,
  output logic [N_MASTERS-1:0] GNT_n,
  output logic [OW-1:0]        Owner,
  output logic                 Owner_valid,
  output logic                 Bus_idle
);

  localparam int TW = clog2(GNT_TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(GNT_TIMEOUT - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  arb_state_e                 state_q, state_d;
  logic [OW-1:0]              win_q, win_d;
  logic                       parked_q, parked_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [N_MASTERS-1:0]       gnt_n_q, gnt_n_d;
  logic [N_MASTERS*AGE_W-1:0] age_q, age_d;
  logic [OW-1:0]              owner_q, owner_d;
  logic                       owner_vld_q, owner_vld_d;
  logic                       bus_idle_q;

  logic [N_MASTERS-1:0] req, win_oh, pick_req;
  logic [OW-1:0]        pick_idx, gnt_idx;
  logic                 pick_vld, frame_start, bus_idle_now;
  logic                 others_req, lower_req, req_w, gnt_any;

  assign req          = ~REQ_n;
  assign win_oh       = N_MASTERS'(1) << win_q;
  assign frame_start  = ~FRAME_n & bus_idle_q;
  assign bus_idle_now = FRAME_n & IRDY_n;
  assign others_req   = |(req & ~win_oh);
  assign lower_req    = |(req & (win_oh - N_MASTERS'(1)));
  assign req_w        = |(req & win_oh);
  // During a transfer the current owner is excluded so hidden arbitration hands over.
  assign pick_req     = (state_q == XFER) ? (req & ~win_oh) : req;

  pci_arb_pick #(
    .N     (N_MASTERS),
    .AGE_W (AGE_W),
    .IDX_W (OW)
  ) u_pick (
    .req_i     (pick_req),
    .age_i     (age_q),
    .mode_i    (Mode),
    .win_idx_o (pick_idx),
    .win_vld_o (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    parked_d = parked_q;
    timer_d  = '0;
    unique case (state_q)
      IDLE, GAP: begin
        if (pick_vld) begin
          state_d  = GRANT;
          win_d    = pick_idx;
          parked_d = 1'b0;
        end else if (PARK_EN) begin
          state_d  = GRANT;
          win_d    = OW'(PARK_IDX);
          parked_d = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        timer_d = (bus_idle_q && !parked_q) ? timer_q + TW'(1) : timer_q;
        if (frame_start) begin
          state_d = XFER;
        end else if (parked_q) begin
          if (|req) state_d = GAP;
        end else if (!req_w || (bus_idle_q && (timer_q == TMO_LAST)) ||
                     (!Mode && bus_idle_q && lower_req)) begin
          state_d = GAP;
        end
      end
      XFER: begin
        if (others_req) begin
          state_d  = GAP;
          win_d    = pick_idx;
          parked_d = 1'b0;
        end else if (bus_idle_now) begin
          state_d  = req_w ? GRANT : IDLE;
          parked_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_n_d = ((state_d == GRANT) || (state_d == XFER)) ? ~(N_MASTERS'(1) << win_d)
                                                              : '1;

  always_comb begin
    age_d = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (req[i] && gnt_n_q[i]) begin
        age_d[i*AGE_W +: AGE_W] = (age_q[i*AGE_W +: AGE_W] == AGE_MAX) ? AGE_MAX
                                : age_q[i*AGE_W +: AGE_W] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (!gnt_n_q[i]) gnt_idx = OW'(i);
    end
  end
  assign gnt_any = ~&gnt_n_q;

  // Owner is whoever held the grant on the cycle before FRAME# fell on an idle bus.
  always_comb begin
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if (frame_start) begin
      owner_vld_d = gnt_any;
      if (gnt_any) owner_d = gnt_idx;
    end else if (bus_idle_now) begin
      owner_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      parked_q    <= 1'b0;
      timer_q     <= '0;
      gnt_n_q     <= '1;
      age_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      bus_idle_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      parked_q    <= parked_d;
      timer_q     <= timer_d;
      gnt_n_q     <= gnt_n_d;
      age_q       <= age_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      bus_idle_q  <= bus_idle_now;
    end
  end

  assign GNT_n       = gnt_n_q;
  assign Owner       = owner_q;
  assign Owner_valid = owner_vld_q;
  assign Bus_idle    = bus_idle_q;

endmodule

// File: tb/tb_pci_arbiter_n.sv
// tb/tb_pci_arbiter_n.sv - scoreboard bench: expected grant/owner changes queued, monitors compare
module tb_pci_arbiter_n;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n, frame_n, irdy_n, mode;
  logic [3:0] req_n, gnt_n;
  logic [1:0] owner;
  logic       owner_valid, bus_idle;

  logic       rstp_n;
  logic [3:0] reqp_n, gntp_n;
  logic [1:0] ownerp;
  logic       ownerp_valid, busp_idle;

  pci_arbiter_n #(
    .N_MASTERS(4), .AGE_W(4), .GNT_TIMEOUT(16), .PARK_EN(1'b0), .PARK_IDX(0)
  ) dut (
    .Clk(clk), .Rst_n(rst_n), .REQ_n(req_n), .FRAME_n(frame_n), .IRDY_n(irdy_n),
    .Mode(mode), .GNT_n(gnt_n), .Owner(owner), .Owner_valid(owner_valid),
    .Bus_idle(bus_idle)
  );

  pci_arbiter_n #(
    .N_MASTERS(4), .AGE_W(4), .GNT_TIMEOUT(16), .PARK_EN(1'b1), .PARK_IDX(0)
  ) dut_pk (
    .Clk(clk), .Rst_n(rstp_n), .REQ_n(reqp_n), .FRAME_n(1'b1), .IRDY_n(1'b1),
    .Mode(1'b0), .GNT_n(gntp_n), .Owner(ownerp), .Owner_valid(ownerp_valid),
    .Bus_idle(busp_idle)
  );

  int  n_checks = 0;
  int  n_errors = 0;
  ev_t q_gnt[$];
  ev_t q_own[$];
  ev_t q_pk[$];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_gnt(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c; e.val = v;
    q_gnt.push_back(e);
  endtask

  task automatic exp_own(input int c, input logic vld, input logic [1:0] idx);
    ev_t e;
    e.cyc = c; e.val = {1'b0, vld, idx};
    q_own.push_back(e);
  endtask

  task automatic exp_pk(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c; e.val = v;
    q_pk.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic score(input string name, inout ev_t q[$], input logic [3:0] got);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: unexpected change to %b at cycle %0d", name, got, cyc);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.val !== got) begin
        n_errors++;
        $display("FAIL %s: got %b at cycle %0d expected %b at cycle %0d",
                 name, got, cyc, e.val, e.cyc);
      end
    end
  endtask

  initial begin : mon_gnt
    logic [3:0] prev;
    prev = 4'hF;
    forever begin
      @(negedge clk);
      if (gnt_n !== prev) begin
        score("gnt", q_gnt, gnt_n);
        prev = gnt_n;
      end
    end
  end

  initial begin : mon_own
    logic [3:0] prev, cur;
    prev = 4'h0;
    forever begin
      @(negedge clk);
      cur = {1'b0, owner_valid, owner};
      if (cur !== prev) begin
        score("owner", q_own, cur);
        prev = cur;
      end
    end
  end

  initial begin : mon_pk
    logic [3:0] prev;
    prev = 4'hF;
    forever begin
      @(negedge clk);
      if (gntp_n !== prev) begin
        score("park_gnt", q_pk, gntp_n);
        prev = gntp_n;
      end
    end
  end

  initial begin : stim
    int         t;
    logic [3:0] g;
    rst_n = 1'b0; rstp_n = 1'b0;
    req_n = 4'hF; reqp_n = 4'hF;
    frame_n = 1'b1; irdy_n = 1'b1; mode = 1'b0;
    step(3);
    check("rst_gnt", 32'(gnt_n), 32'hF);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_owner_valid", 32'(owner_valid), 32'h0);
    check("rst_bus_idle", 32'(bus_idle), 32'h1);
    check("rst_park_gnt", 32'(gntp_n), 32'hF);
    exp_pk(cyc + 1, 4'b1110);
    rst_n = 1'b1; rstp_n = 1'b1;
    step(1);

    // fixed priority, lower-index preemption on an idle bus
    t = cyc; req_n = 4'b1001; exp_gnt(t + 1, 4'b1101);
    step(1); req_n = 4'b1000; exp_gnt(t + 2, 4'hF); exp_gnt(t + 3, 4'b1110);
    step(2); req_n = 4'hF; exp_gnt(t + 4, 4'hF);
    step(3);

    // age priority: all request, 3-cycle transfers, order 0,1,2,3,0
    t = cyc; mode = 1'b1; req_n = 4'h0;
    exp_gnt(t + 1, 4'b1110);
    for (int k = 0; k < 4; k++) begin
      g = 4'b0001 << ((k + 1) % 4);
      exp_gnt(t + 3 + 4*k, 4'hF);
      exp_gnt(t + 4 + 4*k, ~g);
      exp_own(t + 2 + 4*k, 1'b1, 2'(k));
      exp_own(t + 5 + 4*k, 1'b0, 2'(k));
    end
    exp_gnt(t + 17, 4'hF);
    step(1);
    for (int k = 0; k < 4; k++) begin
      frame_n = 1'b0; irdy_n = 1'b0;
      step(3);
      frame_n = 1'b1; irdy_n = 1'b1;
      if (k == 3) req_n = 4'hF;
      step(1);
    end
    step(1); mode = 1'b0;

    // idle-grant timeout on master 2, then re-grant after the gap
    t = cyc; req_n = 4'b1011;
    exp_gnt(t + 1, 4'b1011); exp_gnt(t + 17, 4'hF); exp_gnt(t + 18, 4'b1011);
    step(18); req_n = 4'hF; exp_gnt(t + 19, 4'hF);
    step(3);

    // hidden arbitration: master 1 transferring, master 3 requests
    t = cyc; req_n = 4'b1101; exp_gnt(t + 1, 4'b1101);
    step(1); frame_n = 1'b0; irdy_n = 1'b0; req_n = 4'hF; exp_own(t + 2, 1'b1, 2'd1);
    step(1); req_n = 4'b0111; exp_gnt(t + 3, 4'hF); exp_gnt(t + 4, 4'b0111);
    step(3); frame_n = 1'b1; irdy_n = 1'b1; exp_own(t + 6, 1'b0, 2'd1);
    step(1); frame_n = 1'b0; irdy_n = 1'b0; exp_own(t + 7, 1'b1, 2'd3);
    step(1); req_n = 4'hF;
    step(1); frame_n = 1'b1; irdy_n = 1'b1; exp_gnt(t + 9, 4'hF); exp_own(t + 9, 1'b0, 2'd3);
    step(2);

    // reset in the middle of a transfer
    t = cyc; req_n = 4'b1110; exp_gnt(t + 1, 4'b1110);
    step(1); frame_n = 1'b0; irdy_n = 1'b0; exp_own(t + 2, 1'b1, 2'd0);
    step(1); rst_n = 1'b0; exp_gnt(t + 3, 4'hF); exp_own(t + 3, 1'b0, 2'd0);
    step(1);
    check("midrst_bus_idle", 32'(bus_idle), 32'h1);
    check("midrst_gnt", 32'(gnt_n), 32'hF);
    check("midrst_owner_valid", 32'(owner_valid), 32'h0);
    rst_n = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; req_n = 4'hF;
    step(2);

    // parking: held well past the timeout, then a request takes over
    check("park_hold", 32'(gntp_n), 32'hE);
    check("park_owner_valid", 32'(ownerp_valid), 32'h0);
    check("park_bus_idle", 32'(busp_idle), 32'h1);
    t = cyc; reqp_n = 4'b1011; exp_pk(t + 1, 4'hF); exp_pk(t + 2, 4'b1011);
    step(2); reqp_n = 4'hF; exp_pk(t + 3, 4'hF); exp_pk(t + 4, 4'b1110);
    step(4);

    check("gnt_queue_left", 32'(q_gnt.size()), 32'h0);
    check("owner_queue_left", 32'(q_own.size()), 32'h0);
    check("park_queue_left", 32'(q_pk.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
